decode_front: RTL and testbench
===============================

Name: decode_front

Overview:
- Decode-side partner of the fetch stage. Holds the IF/ID pipeline register and decodes beq/bne. Returns the branch target, the branch select and the fetch stall to fetch.
- Consumes the fetch outputs pc_plus_4f and instructionf. Drives pc_branch_d, pcsrc_d and stallf back to fetch.
- Also detects load-use and branch-operand hazards, and requests a bubble into EX.

Parameters:
- STALL_CNT_W, 16, width of the saturating stalled-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pc_plus_4f  in  32  PC+4 from fetch.
- instructionf  in  32  instruction word from fetch.
- rf_rd1  in  32  register file data for rs_d (combinational read).
- rf_rd2  in  32  register file data for rt_d.
- regwrite_e  in  1  EX instruction writes a register.
- memtoreg_e  in  1  EX instruction is a load.
- write_reg_e  in  5  EX destination register.
- regwrite_m  in  1  MEM instruction writes a register.
- memtoreg_m  in  1  MEM instruction is a load.
- write_reg_m  in  5  MEM destination register.
- alu_out_m  in  32  MEM-stage ALU result (forward source).
- instr_d  out  32  registered instruction.
- pc_plus_4d  out  32  registered PC+4.
- rs_d  out  5  instr_d[25:21].
- rt_d  out  5  instr_d[20:16].
- pc_branch_d  out  32  branch target.
- pcsrc_d  out  1  take branch target next cycle.
- stallf  out  1  hold PC.
- flush_e  out  1  insert bubble into ID/EX.
- stall_count  out  STALL_CNT_W  stalled cycles since reset.

Behaviour:
- Reset (async, rst_n low): instr_d=0 (nop), pc_plus_4d=0, stall_count=0. All combinational outputs follow from these values: pcsrc_d=0, and stallf=0 / flush_e=0 unless an EX/MEM hazard input matches register 0 (excluded below), so both are 0.
- Decode:
  - op = instr_d[31:26].
  - branch_d = (op==6'b000100) | (op==6'b000101).
  - bne when op==6'b000101.
- Forwarding to the comparator:
  - a = (rs_d!=0 & regwrite_m & write_reg_m==rs_d) ? alu_out_m : rf_rd1.
  - b is the same with rt_d and rf_rd2.
  - No forwarding from EX; that case stalls.
- Target: pc_branch_d = pc_plus_4d + ({{14{instr_d[15]}},instr_d[15:0],2'b00}), modulo 2^32, wrap ignored.
- Hazards (a register 0 match never counts):
  - lwstall = memtoreg_e & (write_reg_e==rs_d | write_reg_e==rt_d).
  - branchstall = branch_d & ((regwrite_e & (write_reg_e==rs_d | write_reg_e==rt_d)) | (memtoreg_m & (write_reg_m==rs_d | write_reg_m==rt_d))).
  - stall = lwstall | branchstall.
  - stallf = stall; flush_e = stall.
- Branch:
  - taken = branch_d & ((a==b) ^ bne).
  - pcsrc_d = taken & ~stall; never asserted while stalled.
- IF/ID register update at each posedge clk, in priority order:
  - (1) stall: hold instr_d and pc_plus_4d.
  - (2) pcsrc_d: load instr_d=0, pc_plus_4d=0 (squash the wrong-path fetch; no delay slot).
  - (3) otherwise: load instructionf and pc_plus_4f.
- Latency: a fetched instruction appears on instr_d one cycle after it is presented. Branch resolution is in decode with a 1-cycle penalty.
- stall_count: increments on every posedge where stall=1; saturates at all-ones and never wraps.
- Reset asserted mid-stall: register and counter clear immediately; stall drops once the hazard inputs clear.

Test Plan:
- Reset: hold rst_n=0 with all inputs 0 -> instr_d=0, pc_plus_4d=0, pcsrc_d=0, stallf=0, stall_count=0. Drop rst_n asynchronously between edges -> outputs clear without a clock.
- Straight-line: present pc_plus_4f=0x4, instructionf=0x20080005, then 0x8 / 0x2009000A -> instr_d and pc_plus_4d follow one cycle later; no stall.
- Taken beq with MEM forward: instr_d=0x11090003 (beq $8,$9,+3), pc_plus_4d=0x10, rf_rd1=5, rf_rd2=7, regwrite_m=1, write_reg_m=9, alu_out_m=5 -> pc_branch_d=0x1C, pcsrc_d=1; next edge instr_d=0.
- bne not taken: same operands equal -> pcsrc_d=0; next fetch word loaded normally.
- Load-use: instr_d rs=8, memtoreg_e=1, write_reg_e=8 -> stallf=flush_e=1, instr_d held for 1 cycle, stall_count=1. Clear the hazard -> resume.
- Branch stall then resolve: beq on $9 with regwrite_e=1, write_reg_e=9 -> stall, pcsrc_d=0. Next cycle the hazard moves to MEM with regwrite_m=1, memtoreg_m=0 -> no stall, forward, pcsrc_d correct.
- Counter saturation with STALL_CNT_W=2: hold a stall for 5 cycles -> stall_count=3.

Source files
------------

// File: rtl/decode_front_if.sv
// Fetch/decode link: fetch words in, branch redirect and PC hold out.
// Fetch drives the master side and decode_front takes the slave side.
interface decode_front_if;
  logic [31:0] pc_plus_4f;
  logic [31:0] instructionf;
  logic [31:0] pc_branch_d;
  logic        pcsrc_d;
  logic        stallf;

  modport master (
    output pc_plus_4f,
    output instructionf,
    input  pc_branch_d,
    input  pcsrc_d,
    input  stallf
  );

  modport slave (
    input  pc_plus_4f,
    input  instructionf,
    output pc_branch_d,
    output pcsrc_d,
    output stallf
  );
endinterface

// File: rtl/decode_front.sv
// Decode front end: IF/ID register, beq/bne resolution, hazard stalls.
// Branches resolve in ID with MEM forwarding; EX producers cause a stall.
module decode_front #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  decode_front_if.slave          fch,
  input  logic [31:0]            rf_rd1,
  input  logic [31:0]            rf_rd2,
  input  logic                   regwrite_e,
  input  logic                   memtoreg_e,
  input  logic [4:0]             write_reg_e,
  input  logic                   regwrite_m,
  input  logic                   memtoreg_m,
  input  logic [4:0]             write_reg_m,
  input  logic [31:0]            alu_out_m,
  output logic [31:0]            instr_d,
  output logic [31:0]            pc_plus_4d,
  output logic [4:0]             rs_d,
  output logic [4:0]             rt_d,
  output logic                   flush_e,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [5:0]  op;
  logic        is_beq;
  logic        is_bne;
  logic        branch_d;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [31:0] imm_sh;
  logic        e_hit;
  logic        m_hit;
  logic        lwstall;
  logic        branchstall;
  logic        stall;
  logic        taken;
  logic        pcsrc;

  assign op   = instr_d[31:26];
  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];

  always_comb begin
    is_beq = 1'b0;
    is_bne = 1'b0;
    unique case (1'b1)
      (op == OP_BEQ): is_beq = 1'b1;
      (op == OP_BNE): is_bne = 1'b1;
      default: ;
    endcase
  end

  assign branch_d = is_beq | is_bne;

  // Only MEM results can reach the comparator in time.
  assign fwd_a = (rs_d != 5'd0) & regwrite_m
               & (write_reg_m == rs_d);
  assign fwd_b = (rt_d != 5'd0) & regwrite_m
               & (write_reg_m == rt_d);

  assign cmp_a = fwd_a ? alu_out_m : rf_rd1;
  assign cmp_b = fwd_b ? alu_out_m : rf_rd2;

  assign imm_sh = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign fch.pc_branch_d = pc_plus_4d + imm_sh;

  // $0 is never a real dependency.
  assign e_hit = (write_reg_e != 5'd0)
               & ((write_reg_e == rs_d) | (write_reg_e == rt_d));
  assign m_hit = (write_reg_m != 5'd0)
               & ((write_reg_m == rs_d) | (write_reg_m == rt_d));

  assign lwstall     = memtoreg_e & e_hit;
  assign branchstall = branch_d
                     & ((regwrite_e & e_hit) | (memtoreg_m & m_hit));
  assign stall       = lwstall | branchstall;

  assign taken = branch_d & ((cmp_a == cmp_b) ^ is_bne);
  assign pcsrc = taken & ~stall;

  assign fch.pcsrc_d = pcsrc;
  assign fch.stallf  = stall;
  assign flush_e     = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= '0;
      pc_plus_4d <= '0;
    end else if (stall) begin
      instr_d    <= instr_d;
      pc_plus_4d <= pc_plus_4d;
    end else if (pcsrc) begin
      instr_d    <= '0;
      pc_plus_4d <= '0;
    end else begin
      instr_d    <= fch.instructionf;
      pc_plus_4d <= fch.pc_plus_4f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_front.sv
// Bench for decode_front: vector table plus reset sequences.
// A second instance with a 2-bit counter shares the stimulus.
module tb_decode_front;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc4f, instrf, rd1, rd2, alu_m;
  logic        rw_e, mtr_e, rw_m, mtr_m;
  logic [4:0]  wr_e, wr_m;

  logic [31:0] instr_d0, pc4d0, instr_d1, pc4d1;
  logic [4:0]  rs0, rt0, rs1, rt1;
  logic        flush0, flush1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  decode_front_if f0 ();
  decode_front_if f1 ();

  assign f0.pc_plus_4f   = pc4f;
  assign f0.instructionf = instrf;
  assign f1.pc_plus_4f   = pc4f;
  assign f1.instructionf = instrf;

  always #5 clk = ~clk;

  decode_front #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fch(f0),
    .rf_rd1(rd1), .rf_rd2(rd2),
    .regwrite_e(rw_e), .memtoreg_e(mtr_e), .write_reg_e(wr_e),
    .regwrite_m(rw_m), .memtoreg_m(mtr_m), .write_reg_m(wr_m),
    .alu_out_m(alu_m),
    .instr_d(instr_d0), .pc_plus_4d(pc4d0),
    .rs_d(rs0), .rt_d(rt0), .flush_e(flush0), .stall_count(cnt0)
  );

  decode_front #(.STALL_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fch(f1),
    .rf_rd1(rd1), .rf_rd2(rd2),
    .regwrite_e(rw_e), .memtoreg_e(mtr_e), .write_reg_e(wr_e),
    .regwrite_m(rw_m), .memtoreg_m(mtr_m), .write_reg_m(wr_m),
    .alu_out_m(alu_m),
    .instr_d(instr_d1), .pc_plus_4d(pc4d1),
    .rs_d(rs1), .rt_d(rt1), .flush_e(flush1), .stall_count(cnt1)
  );

  typedef struct {
    logic [31:0] pc4f;
    logic [31:0] instrf;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        rw_e;
    logic        mtr_e;
    logic [4:0]  wr_e;
    logic        rw_m;
    logic        mtr_m;
    logic [4:0]  wr_m;
    logic [31:0] alu_m;
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic [31:0] nxt_instr;
    logic [31:0] nxt_pc4;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    int          cnt;
  } exp_t;

  vec_t tv [17];
  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pc4f   = v.pc4f;
    instrf = v.instrf;
    rd1    = v.rd1;
    rd2    = v.rd2;
    rw_e   = v.rw_e;
    mtr_e  = v.mtr_e;
    wr_e   = v.wr_e;
    rw_m   = v.rw_m;
    mtr_m  = v.mtr_m;
    wr_m   = v.wr_m;
    alu_m  = v.alu_m;
  endtask

  initial begin
    exp_t e;
    int   c2;
    tv[0]  = '{32'h4,  32'h20080005, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0,
               32'h20080005, 32'h4, 0};
    tv[1]  = '{32'h8,  32'h2009000A, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h18,
               32'h2009000A, 32'h8, 0};
    tv[2]  = '{32'h10, 32'h11090003, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h30,
               32'h11090003, 32'h10, 0};
    tv[3]  = '{32'h14, 32'hDEADBEEF, 32'h5, 32'h7, 1'b0, 1'b0, 5'd0,
               1'b1, 1'b0, 5'd9, 32'h5, 1'b0, 1'b1, 32'h1C,
               32'h0, 32'h0, 0};
    tv[4]  = '{32'h20, 32'h15090002, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0,
               32'h15090002, 32'h20, 0};
    tv[5]  = '{32'h24, 32'h01095020, 32'h6, 32'h6, 1'b0, 1'b0, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h28,
               32'h01095020, 32'h24, 0};
    tv[6]  = '{32'h28, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd8,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h140A4,
               32'h01095020, 32'h24, 1};
    tv[7]  = '{32'h28, 32'h11200004, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h140A4,
               32'h11200004, 32'h28, 1};
    tv[8]  = '{32'h2C, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd9,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h38,
               32'h11200004, 32'h28, 2};
    tv[9]  = '{32'h2C, 32'h0, 32'h55, 32'h0, 1'b0, 1'b0, 5'd0,
               1'b1, 1'b0, 5'd9, 32'h0, 1'b0, 1'b1, 32'h38,
               32'h0, 32'h0, 2};
    tv[10] = '{32'h40, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0,
               32'h0, 32'h40, 2};
    tv[11] = '{32'h44, 32'h01095020, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h40,
               32'h01095020, 32'h44, 2};
    for (int k = 0; k < 5; k++)
      tv[12+k] = '{32'h48, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd9,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h140C4,
                   32'h01095020, 32'h44, 3 + k};

    rst_n = 1'b0;
    drive('{default: '0});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_d", instr_d0, 32'h0);
    chk("rst_pc4d", pc4d0, 32'h0);
    chk("rst_pcsrc", {31'b0, f0.pcsrc_d}, 32'h0);
    chk("rst_stallf", {31'b0, f0.stallf}, 32'h0);
    chk("rst_flush", {31'b0, flush0}, 32'h0);
    chk("rst_cnt", {16'b0, cnt0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_stallf", i), {31'b0, f0.stallf},
          {31'b0, tv[i].stall});
      chk($sformatf("v%0d_flush", i), {31'b0, flush0},
          {31'b0, tv[i].stall});
      chk($sformatf("v%0d_pcsrc", i), {31'b0, f0.pcsrc_d},
          {31'b0, tv[i].pcsrc});
      chk($sformatf("v%0d_target", i), f0.pc_branch_d, tv[i].tgt);
      sb.push_back('{tv[i].nxt_instr, tv[i].nxt_pc4, tv[i].cnt});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL v%0d_sb: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        c2 = (e.cnt > 3) ? 3 : e.cnt;
        chk($sformatf("v%0d_instr_d", i), instr_d0, e.instr);
        chk($sformatf("v%0d_pc4d", i), pc4d0, e.pc4);
        chk($sformatf("v%0d_rs", i), {27'b0, rs0},
            {27'b0, e.instr[25:21]});
        chk($sformatf("v%0d_rt", i), {27'b0, rt0},
            {27'b0, e.instr[20:16]});
        chk($sformatf("v%0d_cnt16", i), {16'b0, cnt0}, e.cnt);
        chk($sformatf("v%0d_cnt2", i), {30'b0, cnt1}, c2);
      end
    end

    // Reset dropped mid-stall, away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr_d", instr_d0, 32'h0);
    chk("mid_rst_pc4d", pc4d0, 32'h0);
    chk("mid_rst_cnt16", {16'b0, cnt0}, 32'h0);
    chk("mid_rst_cnt2", {30'b0, cnt1}, 32'h0);
    chk("mid_rst_stallf", {31'b0, f0.stallf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive('{default: '0});
    pc4f   = 32'h4;
    instrf = 32'h20080005;
    @(posedge clk);
    #1;
    chk("post_rst_instr_d", instr_d0, 32'h20080005);
    chk("post_rst_pc4d", pc4d0, 32'h4);
    chk("post_rst_cnt16", {16'b0, cnt0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
